// File: rtl/dcache_responder_pkg.sv
// Shared types, geometry constants and line/word helpers for the data cache.
// Geometry: 8 sets, 16-byte lines (8 x 16-bit words), 9-bit tag.
package dcache_responder_pkg;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [2:0]   lc3b_c_offset;

    localparam int unsigned NUM_SETS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    // Extract one 16-bit word from a line.
    function automatic lc3b_word select_word(input lc3b_line line, input lc3b_c_offset off);
        return line[{off, 4'b0000} +: 16];
    endfunction

    // Merge the enabled byte lanes of wdata into word 'off'; disabled lanes keep old data.
    function automatic lc3b_line merge_word(input lc3b_line line, input lc3b_c_offset off,
                                            input lc3b_word wdata, input logic [1:0] be);
        lc3b_line r;
        r = line;
        r[{off, 4'b0000} +: 8] = be[0] ? wdata[7:0]  : line[{off, 4'b0000} +: 8];
        r[{off, 4'b1000} +: 8] = be[1] ? wdata[15:8] : line[{off, 4'b1000} +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dcache_responder_array.sv
// dcache_array: 8-entry data/tag/valid/dirty storage for the direct-mapped cache.
// Ports: clk_i, reset_i (sync, active-high, clears valid/dirty), index_i selects
// the entry for both the asynchronous read (data_o/tag_o/valid_o/dirty_o) and the
// synchronous per-array writes (load_*_i with *_i data).
module dcache_array
    import dcache_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  lc3b_c_index index_i,
    input  logic        load_data_i,
    input  lc3b_line    data_i,
    input  logic        load_tag_i,
    input  lc3b_c_tag   tag_i,
    input  logic        load_valid_i,
    input  logic        valid_i,
    input  logic        load_dirty_i,
    input  logic        dirty_i,
    output lc3b_line    data_o,
    output lc3b_c_tag   tag_o,
    output logic        valid_o,
    output logic        dirty_o
);

    lc3b_line              data_q [NUM_SETS];
    lc3b_c_tag             tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q;
    logic [NUM_SETS-1:0]   dirty_q;

    // Data and tag storage: contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (load_data_i) begin
            data_q[index_i] <= data_i;
        end
        if (load_tag_i) begin
            tag_q[index_i] <= tag_i;
        end
    end

    // Valid/dirty bits: reset clears every entry and takes priority over loads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (load_valid_i) begin
                valid_q[index_i] <= valid_i;
            end
            if (load_dirty_i) begin
                dirty_q[index_i] <= dirty_i;
            end
        end
    end

    assign data_o  = data_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back data cache between the MEM stage and
// physical memory. Hits answer in the same cycle (rw_resp combinational in IDLE);
// misses write back a dirty victim (pmem_write) and then fill the line (pmem_read)
// over a 128-bit level/acknowledge handshake (pmem_resp).
// Ports: clk, reset (sync, active-high); requester side req_rw, w_en, mem_address,
// mem_wdata, mem_byte_enable -> rw_resp, mem_rdata; memory side pmem_read,
// pmem_write, pmem_address, pmem_wdata <- pmem_rdata, pmem_resp.
module dcache_responder
    import dcache_responder_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         req_rw,
    input  logic         w_en,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic         rw_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    dcache_state_t state_q, state_d;

    lc3b_c_tag    addr_tag_s;
    lc3b_c_index  index_s;
    lc3b_c_offset offset_s;
    logic         addr_unused_s;

    lc3b_line  line_s;
    lc3b_c_tag tag_s;
    logic      valid_s, dirty_s, hit_s;

    logic      load_data_s, load_tag_s, load_valid_s, load_dirty_s, dirty_in_s;
    lc3b_line  data_in_s;

    assign addr_tag_s    = mem_address[15:7];
    assign index_s       = mem_address[6:4];
    assign offset_s      = mem_address[3:1];
    assign addr_unused_s = mem_address[0];

    assign hit_s = req_rw & valid_s & (tag_s == addr_tag_s);

    dcache_array u_array (
        .clk_i        (clk),
        .reset_i      (reset),
        .index_i      (index_s),
        .load_data_i  (load_data_s),
        .data_i       (data_in_s),
        .load_tag_i   (load_tag_s),
        .tag_i        (addr_tag_s),
        .load_valid_i (load_valid_s),
        .valid_i      (1'b1),
        .load_dirty_i (load_dirty_s),
        .dirty_i      (dirty_in_s),
        .data_o       (line_s),
        .tag_o        (tag_s),
        .valid_o      (valid_s),
        .dirty_o      (dirty_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped request ends the miss once the current pmem transaction is acknowledged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_rw && !hit_s) begin
                    state_d = (valid_s && dirty_s) ? WRITEBACK : ALLOCATE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = req_rw ? ALLOCATE : IDLE;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and array write controls for each state.
    always_comb begin
        rw_resp      = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        load_data_s  = 1'b0;
        load_tag_s   = 1'b0;
        load_valid_s = 1'b0;
        load_dirty_s = 1'b0;
        dirty_in_s   = 1'b0;
        data_in_s    = pmem_rdata;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    rw_resp   = 1'b1;
                    mem_rdata = select_word(line_s, offset_s);
                    if (w_en) begin
                        // Even an all-lanes-disabled write marks the line dirty.
                        data_in_s    = merge_word(line_s, offset_s, mem_wdata, mem_byte_enable);
                        load_data_s  = 1'b1;
                        load_dirty_s = 1'b1;
                        dirty_in_s   = 1'b1;
                    end else begin
                        load_data_s  = 1'b0;
                    end
                end else begin
                    rw_resp = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_s, index_s, 4'b0000};
                pmem_wdata   = line_s;
                if (pmem_resp) begin
                    load_dirty_s = 1'b1;
                    dirty_in_s   = 1'b0;
                end else begin
                    load_dirty_s = 1'b0;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'b0000};
                if (pmem_resp) begin
                    load_data_s  = 1'b1;
                    load_tag_s   = 1'b1;
                    load_valid_s = 1'b1;
                    load_dirty_s = 1'b1;
                    dirty_in_s   = 1'b0;
                end else begin
                    load_data_s  = 1'b0;
                end
            end
            default: begin
                rw_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed test-plan steps followed by
// randomized requests, checked against a coherent-memory reference view plus a
// per-set hit/miss/dirty model.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         reset, req_rw, w_en, pmem_resp;
    logic [15:0]  mem_address, mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic         rw_resp, pmem_read, pmem_write;
    logic [15:0]  mem_rdata, pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: backing memory and the coherent word view seen by the requester.
    logic [15:0] bmem [int];
    logic [15:0] flat [int];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [8:0]  m_tag   [8];
    logic [15:0] last_rd;

    dcache_responder dut (
        .clk(clk), .reset(reset), .req_rw(req_rw), .w_en(w_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .rw_resp(rw_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bword(input logic [14:0] wa);
        if (bmem.exists(int'(wa))) return bmem[int'(wa)];
        return {1'b0, wa} ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] fword(input logic [14:0] wa);
        if (flat.exists(int'(wa))) return flat[int'(wa)];
        return bword(wa);
    endfunction

    function automatic logic [127:0] bline(input logic [11:0] la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = bword({la, 3'(w)});
        return l;
    endfunction

    function automatic logic [127:0] fline(input logic [11:0] la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = fword({la, 3'(w)});
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        flat.delete();
    endtask

    // One request with pmem latency 'lat' cycles before each acknowledge.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input int lat);
        logic [2:0]  idx;
        logic [11:0] vla;
        logic [15:0] old;
        bit hit, vdirty, done, wb_done;
        int exp_cyc, cyc, wcnt;
        idx     = a[6:4];
        hit     = m_valid[idx] && (m_tag[idx] == a[15:7]);
        vdirty  = !hit && m_valid[idx] && m_dirty[idx];
        vla     = {m_tag[idx], idx};
        exp_cyc = hit ? 1 : 2 + (lat + 1) * (vdirty ? 2 : 1);
        @(negedge clk);
        req_rw = 1'b1; w_en = w; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        cyc = 0; wcnt = 0; done = 1'b0; wb_done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            cyc++;
            if (cyc == 1 && !hit) chk("miss_c0_pmem_idle", 128'(pmem_read | pmem_write), 128'd0);
            if (rw_resp) begin
                done = 1'b1;
                chk("latency", 128'(cyc), 128'(exp_cyc));
                if (!w) begin
                    chk("rdata", 128'(mem_rdata), 128'(fword(a[15:1])));
                    last_rd = mem_rdata;
                end
            end else begin
                chk("pmem_exclusive", 128'(pmem_read & pmem_write), 128'd0);
                if (pmem_write) begin
                    chk("wb_expected", 128'(vdirty), 128'd1);
                    chk("wb_addr", 128'(pmem_address), 128'({vla, 4'b0000}));
                    chk("wb_data", pmem_wdata, fline(vla));
                    if (wcnt == lat) begin
                        pmem_resp = 1'b1; wcnt = 0; wb_done = 1'b1;
                    end else wcnt++;
                end else if (pmem_read) begin
                    chk("fill_order", 128'(wb_done || !vdirty), 128'd1);
                    chk("fill_addr", 128'(pmem_address), 128'({a[15:4], 4'b0000}));
                    pmem_rdata = bline(a[15:4]);
                    if (wcnt == lat) begin
                        pmem_resp = 1'b1; wcnt = 0;
                    end else wcnt++;
                end
            end
            if (!done) begin
                @(negedge clk);
                pmem_resp = 1'b0;
            end
        end
        if (!done) chk("timeout", 128'd0, 128'd1);
        // Model update: write-back of the coherent victim, fill, then the write hit.
        if (!hit) begin
            if (vdirty) for (int k = 0; k < 8; k++) bmem[int'({vla, 3'(k)})] = fword({vla, 3'(k)});
            m_valid[idx] = 1'b1; m_tag[idx] = a[15:7]; m_dirty[idx] = 1'b0;
        end
        if (w) begin
            old = fword(a[15:1]);
            flat[int'(a[15:1])] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; req_rw = 1'b0; w_en = 1'b0; mem_address = 16'h0; mem_wdata = 16'h0;
        mem_byte_enable = 2'b00; pmem_resp = 1'b0; pmem_rdata = 128'h0; last_rd = 16'h0;
        model_reset();
        bmem[int'(15'(16'h3046 >> 1))] = 16'hBEEF;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rw_resp", 128'(rw_resp), 128'd0);
        chk("rst_pmem_read", 128'(pmem_read), 128'd0);
        chk("rst_pmem_write", 128'(pmem_write), 128'd0);
        chk("rst_pmem_address", 128'(pmem_address), 128'd0);
        chk("rst_pmem_wdata", pmem_wdata, 128'd0);
        chk("rst_mem_rdata", 128'(mem_rdata), 128'd0);

        // Cold read, hit, byte write, read-back, dirty eviction.
        do_req(1'b0, 16'h3046, 16'h0000, 2'b00, 2);
        chk("cold_read_beef", 128'(last_rd), 128'(16'hBEEF));
        do_req(1'b0, 16'h3040, 16'h0000, 2'b00, 0);
        do_req(1'b1, 16'h3046, 16'h12AB, 2'b01, 0);
        do_req(1'b0, 16'h3046, 16'h0000, 2'b00, 0);
        chk("byte_merge", 128'(last_rd), 128'(16'hBEAB));
        do_req(1'b0, 16'h5046, 16'h0000, 2'b00, 1);
        chk("evict_wb_word3", 128'(bmem[int'(15'(16'h3046 >> 1))]), 128'(16'hBEAB));
        do_req(1'b1, 16'h3048, 16'h5A5A, 2'b00, 0);

        // Reset while a write-back is in flight.
        do_req(1'b1, 16'h5046, 16'h1111, 2'b11, 0);
        @(negedge clk);
        req_rw = 1'b1; w_en = 1'b0; mem_address = 16'h3046;
        #1 chk("rwb_c0_resp", 128'(rw_resp), 128'd0);
        @(negedge clk);
        #1 chk("rwb_write_up", 128'(pmem_write), 128'd1);
        chk("rwb_addr", 128'(pmem_address), 128'(16'h5040));
        reset = 1'b1; req_rw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rwb_write_dropped", 128'(pmem_write), 128'd0);
        chk("rwb_read_low", 128'(pmem_read), 128'd0);
        model_reset();
        do_req(1'b0, 16'h5046, 16'h0000, 2'b00, 1);

        // Requester abandons a clean miss during ALLOCATE.
        @(negedge clk);
        req_rw = 1'b1; w_en = 1'b0; mem_address = 16'h7026;
        #1 chk("abort_c0_resp", 128'(rw_resp), 128'd0);
        @(negedge clk);
        #1 chk("abort_fill_up", 128'(pmem_read), 128'd1);
        chk("abort_fill_addr", 128'(pmem_address), 128'(16'h7020));
        req_rw = 1'b0;
        @(negedge clk);
        #1 chk("abort_hold", 128'(pmem_read), 128'd1);
        chk("abort_no_resp", 128'(rw_resp), 128'd0);
        pmem_rdata = bline(12'h702);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1 chk("abort_fill_done", 128'(pmem_read | pmem_write), 128'd0);
        chk("abort_still_no_resp", 128'(rw_resp), 128'd0);
        m_valid[2] = 1'b1; m_tag[2] = 9'(16'h7026 >> 7); m_dirty[2] = 1'b0;
        do_req(1'b0, 16'h7026, 16'h0000, 2'b00, 0);

        // Randomized traffic over a few conflicting tags.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra;
            ra = {9'($urandom_range(0, 3)) + 9'h0A0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            do_req(1'($urandom_range(0, 1)), ra, 16'($urandom), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3));
        end

        @(negedge clk);
        req_rw = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-back data cache that answers the datapath's data-memory requests (`req_rw`/`w_en`) with `rw_resp`. It sits between the MEM stage's data-request controller and physical memory. Hits respond in the same cycle. Misses stall the requester while a dirty victim line is written back and the target line is filled over a 128-bit physical-memory handshake.

## Interface
- No parameters. Geometry is fixed by package constants: 8 sets, 16-byte lines (8 words), 9-bit tag.
- `clk` in 1: sole clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_rw` in 1: request valid; the requester holds it, and all request fields, until `rw_resp`.
- `w_en` in 1: 1 = write, 0 = read; meaningful only while `req_rw`=1.
- `mem_address` in 16: byte address. Fields: `[15:7]` tag, `[6:4]` index, `[3:1]` word, `[0]` ignored.
- `mem_wdata` in 16: write data, in word lanes.
- `mem_byte_enable` in 2: bit0 = low byte, bit1 = high byte. Reads ignore it.
- `rw_resp` out 1: request complete.
- `mem_rdata` out 16: selected word; valid when `rw_resp`=1 on a read.
- `pmem_read` out 1: line-fill request.
- `pmem_write` out 1: line write-back request.
- `pmem_address` out 16: line address, `[3:0]`=0.
- `pmem_wdata` out 128: victim line.
- `pmem_rdata` in 128: fill line.
- `pmem_resp` in 1: one-cycle acknowledge of the current pmem transaction.

## Operation
- **States:**
  - IDLE: compare/hit.
  - WRITEBACK.
  - ALLOCATE.
- **Hit** = `req_rw` & valid[index] & (tag[index]==`mem_address[15:7]`).
- **IDLE, hit:**
  - `rw_resp`=1 combinationally.
  - Read: `mem_rdata` = word `[3:1]` of the line.
  - Write: merge the enabled byte lanes into that word and set dirty[index] at the clock edge.
  - State stays IDLE.
- **IDLE, miss:**
  - Victim valid & dirty → WRITEBACK.
  - Otherwise → ALLOCATE.
  - `rw_resp`=0.
- **WRITEBACK:**
  - `pmem_write`=1, `pmem_address`={victim tag, index, 4'b0}, `pmem_wdata`=victim line.
  - On `pmem_resp`: clear dirty, go to ALLOCATE.
- **ALLOCATE:**
  - `pmem_read`=1, `pmem_address`={`mem_address[15:4]`, 4'b0}.
  - On `pmem_resp`: write `pmem_rdata` to the line, tag ← address tag, valid ← 1, dirty ← 0, go to IDLE.
  - The request then hits in IDLE. A write miss therefore completes as fill followed by a write hit.
- **Requester drops `req_rw` mid-miss:** the current pmem transaction completes and the FSM returns to IDLE. No `rw_resp` is issued.
- **`pmem_resp` in IDLE** is ignored.
- **Byte merge:** each lane with its enable at 0 keeps its old value. `mem_byte_enable`=2'b00 on a write is still a hit that sets dirty.
- **Reset:**
  - All valid and dirty bits cleared; data and tags are don't-care; state ← IDLE.
  - An in-flight write-back is abandoned and its data lost.
  - `pmem_read`/`pmem_write` are 0 in the cycle after reset is sampled.

## Timing
- **Output reset values:** `rw_resp`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `mem_rdata`=0.
- **Hit latency:** 0 cycles. `rw_resp` is asserted in the same cycle as `req_rw`, and a write commits on that edge.
- **Clean miss:**
  - Cycle 0: IDLE.
  - Cycle 1: ALLOCATE, held until `pmem_resp`; call the response cycle N.
  - Cycle N+1: IDLE with `rw_resp`=1.
- **Dirty miss:** the same sequence with a WRITEBACK phase inserted before ALLOCATE.
- **pmem handshake:**
  - `pmem_read`/`pmem_write` are held level with stable address/data until `pmem_resp`.
  - They are never both 1.
  - They deassert the cycle after `pmem_resp`.
- **Request stability:** `mem_address`/`w_en`/`mem_wdata` must be stable while `req_rw`=1. The cache does not latch them.
- **Back-to-back hits:** a new request may be presented the cycle after `rw_resp`. It is serviced at 0 latency with no bubble.

## Structure
- **Add to `lc3b_types`:**
  - `lc3b_line` (128-bit).
  - `lc3b_c_tag` (9-bit), `lc3b_c_index` (3-bit), `lc3b_c_offset` (3-bit word select).
  - Enum `dcache_state_t` {IDLE, WRITEBACK, ALLOCATE}.
- **Sub-module `dcache_array`:**
  - 8-entry arrays for data, tag, valid and dirty.
  - Asynchronous read, synchronous write.
  - Per-array load enables and a synchronous clear of valid/dirty on `reset`.
- **Top level:** the FSM, hit compare, word/byte merge mux and pmem address mux.

## Test plan
- **Cold read:** after reset, read `0x3046`.
  - Expect ALLOCATE with `pmem_address`=`0x3040`.
  - Return a line whose word 3 is `0xBEEF`. Expect `rw_resp` with `mem_rdata`=`0xBEEF` one cycle after `pmem_resp`. `pmem_write` is never raised.
- **Hit:** read `0x3040` next.
  - Expect `rw_resp`=1 in the same cycle and no pmem activity.
- **Byte write:** write `0x12AB` with `mem_byte_enable`=2'b01 to `0x3046` (line holds `0xBEEF`).
  - Expect a 0-latency `rw_resp`. A subsequent read returns `0xBEAB`.
- **Dirty eviction:** read `0x5046` (same index 4, different tag).
  - Expect WRITEBACK with `pmem_address`=`0x3040` and `pmem_wdata` word 3 = `0xBEAB`.
  - Then ALLOCATE at `0x5040`, then `rw_resp`.
- **Requester abort:** start a miss, then drop `req_rw` during ALLOCATE.
  - The fill completes, `rw_resp` stays 0, and the FSM ends in IDLE.
- **Reset mid-WRITEBACK:** assert `reset` for one cycle during WRITEBACK.
  - Next cycle: `pmem_write`=0.
  - A read of the old address misses: all valid bits are clear.
